input_conditioner: RTL and testbench

Parametrised successor to the team's 2-FF synchronizer: a WIDTH-channel conditioner for asynchronous inputs such as buttons, switches and external strobes.
- Per channel: configurable-depth synchronizer, then a tick-sampled debouncer, then edge detection.
- Sits in io_circuits between board pins and the MMIO/UART-side logic.
- Replaces the ad-hoc synchronizer + debouncer + edge-detector chains.

---
 rtl/input_conditioner_pkg.sv | 26 ++
 rtl/input_conditioner_debounce_channel.sv | 73 +++++++
 rtl/input_conditioner.sv | 82 ++++++++
 tb/tb_input_conditioner.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/input_conditioner_pkg.sv
`default_nettype none
// ============================================================================
// Module  : input_conditioner_pkg
// Purpose : Shared constants and the width helper for the input conditioner
//           and its per-channel debounce slice.
// Rev     : 1.0  initial release
// ============================================================================
package input_conditioner_pkg;

    localparam int c_DEF_SAMPLE_PERIOD = 1000;
    localparam int c_DEF_STABLE_COUNT  = 8;
    localparam int c_MIN_STAGES        = 2;
    localparam int c_MAX_STAGES        = 4;

    // Bits needed to hold values 0..value-1, never less than one bit.
    function automatic int clog2_min1(input int value);
        int bits;
        bits = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            bits = bits + 1;
        end
        return (bits < 1) ? 1 : bits;
    endfunction

endpackage : input_conditioner_pkg
`default_nettype wire

// File: rtl/input_conditioner_debounce_channel.sv
`default_nettype none
// ============================================================================
// Module  : debounce_channel
// Purpose : One conditioner slice: STAGES-deep synchronizer, tick-sampled
//           stable counter holding the debounced level, and a one-cycle
//           delayed copy of that level for edge detection.
// Rev     : 1.0  initial release
// ============================================================================
module debounce_channel
    import input_conditioner_pkg::*;
#(
    parameter int STAGES       = 2,
    parameter int STABLE_COUNT = c_DEF_STABLE_COUNT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    input  logic tick,
    output logic sync_out,
    output logic level_out,
    output logic level_q
);

    localparam int                  c_CNT_W    = clog2_min1(STABLE_COUNT + 1);
    localparam logic [c_CNT_W-1:0]  c_CNT_LAST = c_CNT_W'(STABLE_COUNT - 1);
    localparam logic [c_CNT_W-1:0]  c_CNT_ONE  = c_CNT_W'(1);

    logic [STAGES-1:0]  r_sync;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_level;
    logic               r_level_q;

    // Shift the raw pin through the synchronizer chain; oldest stage is the output.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], async_in};
        end
    end

    // On each sample tick, count consecutive samples that disagree with the level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else if (tick) begin
            if (r_sync[STAGES-1] == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_LAST) begin
                r_level <= r_sync[STAGES-1];
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + c_CNT_ONE;
            end
        end
    end

    // Delayed level copy so edges come from two registers, never from logic.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_level_q <= 1'b0;
        end else begin
            r_level_q <= r_level;
        end
    end

    assign sync_out  = r_sync[STAGES-1];
    assign level_out = r_level;
    assign level_q   = r_level_q;

endmodule : debounce_channel
`default_nettype wire

// File: rtl/input_conditioner.sv
`default_nettype none
// ============================================================================
// Module  : input_conditioner
// Purpose : WIDTH-channel synchronizer + debouncer + edge detector for
//           asynchronous board inputs. One shared sample-tick counter drives
//           every channel.
// Options : INPUT_COND_FALL_EDGE_EN adds the fall_pulse output.
// Rev     : 1.0  initial release
// ============================================================================
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int WIDTH         = 1,
    parameter int STAGES        = 2,
    parameter int SAMPLE_PERIOD = c_DEF_SAMPLE_PERIOD,
    parameter int STABLE_COUNT  = c_DEF_STABLE_COUNT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out,
    output logic [WIDTH-1:0] level_out,
`ifdef INPUT_COND_FALL_EDGE_EN
    output logic [WIDTH-1:0] fall_pulse,
`endif
    output logic [WIDTH-1:0] rise_pulse
);

    localparam int                   c_TICK_W    = clog2_min1(SAMPLE_PERIOD);
    localparam logic [c_TICK_W-1:0]  c_TICK_LAST = c_TICK_W'(SAMPLE_PERIOD - 1);
    localparam logic [c_TICK_W-1:0]  c_TICK_ONE  = c_TICK_W'(1);

    // Reject illegal configurations at elaboration time.
    if (STAGES < c_MIN_STAGES || STAGES > c_MAX_STAGES) begin : g_bad_stages
        $error("input_conditioner: STAGES must be in 2..4");
    end
    if (SAMPLE_PERIOD < 1) begin : g_bad_sample_period
        $error("input_conditioner: SAMPLE_PERIOD must be >= 1");
    end
    if (STABLE_COUNT < 1) begin : g_bad_stable_count
        $error("input_conditioner: STABLE_COUNT must be >= 1");
    end

    logic [c_TICK_W-1:0] r_tick_cnt;
    logic                w_tick;
    logic [WIDTH-1:0]    w_level_q;

    assign w_tick = (r_tick_cnt == c_TICK_LAST);

    // Free-running sample counter, wraps after SAMPLE_PERIOD cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + c_TICK_ONE;
        end
    end

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_channel
        debounce_channel #(
            .STAGES       (STAGES),
            .STABLE_COUNT (STABLE_COUNT)
        ) u_channel (
            .clk       (clk),
            .rst_n     (rst_n),
            .async_in  (async_in[gi]),
            .tick      (w_tick),
            .sync_out  (sync_out[gi]),
            .level_out (level_out[gi]),
            .level_q   (w_level_q[gi])
        );
    end

    assign rise_pulse = level_out & ~w_level_q;
`ifdef INPUT_COND_FALL_EDGE_EN
    assign fall_pulse = ~level_out & w_level_q;
`endif

endmodule : input_conditioner
`default_nettype wire

// File: tb/tb_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module  : tb_input_conditioner
// Purpose : Self-checking bench. DUT A: WIDTH=2, STAGES=2, SAMPLE_PERIOD=4,
//           STABLE_COUNT=3. DUT B: WIDTH=1, STAGES=3, SAMPLE_PERIOD=1,
//           STABLE_COUNT=1. A cycle-level reference model predicts outputs.
// Options : INPUT_COND_FALL_EDGE_EN enables fall_pulse checking.
// Rev     : 1.0  initial release
// ============================================================================
module tb_input_conditioner;

    logic       clk = 1'b0;
    logic       a_rst_n = 1'b0;
    logic       b_rst_n = 1'b0;
    logic [1:0] a_async = '0;
    logic [0:0] b_async = '0;
    logic [1:0] a_sync, a_level, a_rise;
    logic [0:0] b_sync, b_level, b_rise;
`ifdef INPUT_COND_FALL_EDGE_EN
    logic [1:0] a_fall;
    logic [0:0] b_fall;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    input_conditioner #(.WIDTH(2), .STAGES(2), .SAMPLE_PERIOD(4), .STABLE_COUNT(3)) u_dut_a (
        .clk        (clk),
        .rst_n      (a_rst_n),
        .async_in   (a_async),
        .sync_out   (a_sync),
        .level_out  (a_level),
`ifdef INPUT_COND_FALL_EDGE_EN
        .fall_pulse (a_fall),
`endif
        .rise_pulse (a_rise)
    );

    input_conditioner #(.WIDTH(1), .STAGES(3), .SAMPLE_PERIOD(1), .STABLE_COUNT(1)) u_dut_b (
        .clk        (clk),
        .rst_n      (b_rst_n),
        .async_in   (b_async),
        .sync_out   (b_sync),
        .level_out  (b_level),
`ifdef INPUT_COND_FALL_EDGE_EN
        .fall_pulse (b_fall),
`endif
        .rise_pulse (b_rise)
    );

    // ---------------- reference model (index 0 = DUT A, 1 = DUT B) ----------
    logic [1:0] m_hist [2][4];   // m_hist[k][n] = input seen n+1 edges ago
    int         m_cyc  [2];      // edges since reset release
    logic [1:0] m_lvl  [2];
    logic [1:0] m_prev [2];      // level one cycle ago
    int         m_run  [2][2];   // consecutive disagreeing samples per channel

    function automatic int p_st(input int k); return (k == 0) ? 2 : 3; endfunction
    function automatic int p_sp(input int k); return (k == 0) ? 4 : 1; endfunction
    function automatic int p_sc(input int k); return (k == 0) ? 3 : 1; endfunction

    function automatic logic [1:0] e_sync(input int k); return m_hist[k][p_st(k)-1]; endfunction
    function automatic logic [1:0] e_rise(input int k); return m_lvl[k] & ~m_prev[k]; endfunction
    function automatic logic [1:0] e_fall(input int k); return ~m_lvl[k] & m_prev[k]; endfunction

    task automatic model_edge(input int k, input logic rst_v, input logic [1:0] a);
        logic [1:0] seen;
        logic [1:0] lvl_before;
        bit         sample;
        if (!rst_v) begin
            for (int s = 0; s < 4; s++) m_hist[k][s] = '0;
            m_cyc[k]    = 0;
            m_lvl[k]    = '0;
            m_prev[k]   = '0;
            m_run[k][0] = 0;
            m_run[k][1] = 0;
        end else begin
            seen       = m_hist[k][p_st(k)-1];
            sample     = ((m_cyc[k] % p_sp(k)) == p_sp(k) - 1);
            lvl_before = m_lvl[k];
            m_prev[k]  = lvl_before;
            if (sample) begin
                for (int ch = 0; ch < 2; ch++) begin
                    if (seen[ch] == lvl_before[ch]) begin
                        m_run[k][ch] = 0;
                    end else begin
                        m_run[k][ch] = m_run[k][ch] + 1;
                        if (m_run[k][ch] == p_sc(k)) begin
                            m_lvl[k][ch] = seen[ch];
                            m_run[k][ch] = 0;
                        end
                    end
                end
            end
            for (int s = 3; s > 0; s--) m_hist[k][s] = m_hist[k][s-1];
            m_hist[k][0] = a;
            m_cyc[k]     = m_cyc[k] + 1;
        end
    endtask

    // Drive inputs between edges, advance one clock, update the model, settle.
    task automatic step(input logic [1:0] a, input logic b);
        a_async = a;
        b_async = b;
        @(posedge clk);
        model_edge(0, a_rst_n, a);
        model_edge(1, b_rst_n, {1'b0, b});
        #1;
    endtask

    task automatic do_reset();
        a_rst_n = 1'b0;
        b_rst_n = 1'b0;
        step(2'b00, 1'b0);
        step(2'b00, 1'b0);
        a_rst_n = 1'b1;
        b_rst_n = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        a_rst_n = 1'b0;
        b_rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(2'b11, 1'b1);
            n_checks++;
            if ({a_sync, a_level, a_rise} !== 6'b0)
                $display("FAIL reset_a cyc=%0d got sync/level/rise=%b required 000000", i, {a_sync, a_level, a_rise});
            else n_pass++;
            n_checks++;
            if ({b_sync, b_level, b_rise} !== 3'b0)
                $display("FAIL reset_b cyc=%0d got sync/level/rise=%b required 000", i, {b_sync, b_level, b_rise});
            else n_pass++;
        end
        a_rst_n = 1'b1;
        b_rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(2'b11, 1'b1);
            n_checks++;
            if ({a_rise, b_rise} !== 3'b0)
                $display("FAIL reset_release cyc=%0d got rise a/b=%b required 000", i, {a_rise, b_rise});
            else n_pass++;
        end
    endtask

    task automatic test_clean_rise();
        int n_r0 = 0, n_r1 = 0, t_sync = -1, t_level = -1, t_rise = -1;
        do_reset();
        for (int i = 1; i <= 30; i++) begin
            step(2'b01, 1'b0);
            n_checks++;
            if ({a_sync, a_level, a_rise} !== {e_sync(0), m_lvl[0], e_rise(0)})
                $display("FAIL clean_rise_model cyc=%0d got %b required %b", i,
                         {a_sync, a_level, a_rise}, {e_sync(0), m_lvl[0], e_rise(0)});
            else n_pass++;
            if (a_sync[0] && t_sync < 0) t_sync = i;
            if (a_level[0] && t_level < 0) t_level = i;
            if (a_rise[0]) begin n_r0++; if (t_rise < 0) t_rise = i; end
            if (a_rise[1] || a_level[1]) n_r1++;
        end
        n_checks++;
        if (t_sync !== 2) $display("FAIL clean_rise_sync_latency got %0d required 2", t_sync); else n_pass++;
        n_checks++;
        if (t_level !== 12) $display("FAIL clean_rise_level_latency got %0d required 12", t_level); else n_pass++;
        n_checks++;
        if (n_r0 !== 1 || t_rise !== 12)
            $display("FAIL clean_rise_pulse got count=%0d at=%0d required count=1 at=12", n_r0, t_rise);
        else n_pass++;
        n_checks++;
        if (n_r1 !== 0) $display("FAIL clean_rise_ch1_quiet got %0d active cycles required 0", n_r1); else n_pass++;
    endtask

    task automatic test_glitch();
        int n_bad = 0;
        do_reset();
        for (int i = 0; i < 28; i++) begin
            step((i < 8) ? 2'b10 : 2'b00, 1'b0);
            n_checks++;
            if ({a_sync, a_level, a_rise} !== {e_sync(0), m_lvl[0], e_rise(0)})
                $display("FAIL glitch_model cyc=%0d got %b required %b", i,
                         {a_sync, a_level, a_rise}, {e_sync(0), m_lvl[0], e_rise(0)});
            else n_pass++;
            if (a_level[1] || a_rise[1]) n_bad++;
        end
        n_checks++;
        if (n_bad !== 0) $display("FAIL glitch_rejected got %0d active cycles required 0", n_bad); else n_pass++;
    endtask

    task automatic test_simultaneous();
        int n_both = 0, n_any = 0, n_fb = 0, n_fa = 0;
        do_reset();
        for (int i = 0; i < 60; i++) begin
            step((i < 30) ? 2'b11 : 2'b00, 1'b0);
            n_checks++;
            if ({a_sync, a_level, a_rise} !== {e_sync(0), m_lvl[0], e_rise(0)})
                $display("FAIL simult_model cyc=%0d got %b required %b", i,
                         {a_sync, a_level, a_rise}, {e_sync(0), m_lvl[0], e_rise(0)});
            else n_pass++;
            if (a_rise == 2'b11) n_both++;
            if (a_rise != 2'b00) n_any++;
`ifdef INPUT_COND_FALL_EDGE_EN
            if (a_fall == 2'b11) n_fb++;
            if (a_fall != 2'b00) n_fa++;
`endif
        end
        n_checks++;
        if (n_both !== 1 || n_any !== 1)
            $display("FAIL simult_rise got both=%0d any=%0d required 1/1", n_both, n_any);
        else n_pass++;
`ifdef INPUT_COND_FALL_EDGE_EN
        n_checks++;
        if (n_fb !== 1 || n_fa !== 1)
            $display("FAIL simult_fall got both=%0d any=%0d required 1/1", n_fb, n_fa);
        else n_pass++;
`endif
    endtask

    task automatic test_reset_mid();
        int guard = 0, t_level = -1;
        do_reset();
        while (m_run[0][0] < 2 && guard < 40) begin
            step(2'b01, 1'b0);
            guard++;
        end
        n_checks++;
        if (m_run[0][0] != 2) $display("FAIL reset_mid_setup got run=%0d required 2", m_run[0][0]); else n_pass++;
        a_rst_n = 1'b0;
        step(2'b01, 1'b0);
        a_rst_n = 1'b1;
        n_checks++;
        if ({a_sync, a_level} !== 4'b0) $display("FAIL reset_mid_clear got %b required 0000", {a_sync, a_level}); else n_pass++;
        for (int i = 1; i <= 40 && t_level < 0; i++) begin
            step(2'b01, 1'b0);
            n_checks++;
            if ({a_sync, a_level, a_rise} !== {e_sync(0), m_lvl[0], e_rise(0)})
                $display("FAIL reset_mid_model cyc=%0d got %b required %b", i,
                         {a_sync, a_level, a_rise}, {e_sync(0), m_lvl[0], e_rise(0)});
            else n_pass++;
            if (a_level[0]) t_level = i;
        end
        n_checks++;
        if (t_level !== 12) $display("FAIL reset_mid_fresh_ticks got level at %0d required 12", t_level); else n_pass++;
    endtask

    task automatic test_fast();
        int t_sync = -1, t_level = -1;
        do_reset();
        for (int i = 0; i < 3; i++) step(2'b00, 1'b0);
        for (int i = 0; i < 24; i++) begin
            step(2'b00, (i < 12) ? 1'b1 : 1'b0);
            n_checks++;
            if ({b_sync, b_level, b_rise} !== {e_sync(1)[0], m_lvl[1][0], e_rise(1)[0]})
                $display("FAIL fast_model cyc=%0d got %b required %b", i,
                         {b_sync, b_level, b_rise}, {e_sync(1)[0], m_lvl[1][0], e_rise(1)[0]});
            else n_pass++;
`ifdef INPUT_COND_FALL_EDGE_EN
            n_checks++;
            if (b_fall !== e_fall(1)[0])
                $display("FAIL fast_fall cyc=%0d got %b required %b", i, b_fall, e_fall(1)[0]);
            else n_pass++;
`endif
            if (b_sync[0] && t_sync < 0) t_sync = i;
            if (b_level[0] && t_level < 0) t_level = i;
        end
        n_checks++;
        if (t_sync !== 2 || t_level !== 3)
            $display("FAIL fast_latency got sync@%0d level@%0d required sync@2 level@3", t_sync, t_level);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [1:0] ra = 2'b00;
        logic       rb = 1'b0;
        do_reset();
        for (int i = 0; i < 900; i++) begin
            if ($urandom_range(0, 13) == 0) ra[0] = ~ra[0];
            if ($urandom_range(0, 9) == 0)  ra[1] = ~ra[1];
            if ($urandom_range(0, 3) == 0)  rb = ~rb;
            a_rst_n = ($urandom_range(0, 299) != 0);
            b_rst_n = ($urandom_range(0, 299) != 0);
            step(ra, rb);
            n_checks++;
            if ({a_sync, a_level, a_rise} !== {e_sync(0), m_lvl[0], e_rise(0)})
                $display("FAIL random_a cyc=%0d got %b required %b", i,
                         {a_sync, a_level, a_rise}, {e_sync(0), m_lvl[0], e_rise(0)});
            else n_pass++;
            n_checks++;
            if ({b_sync, b_level, b_rise} !== {e_sync(1)[0], m_lvl[1][0], e_rise(1)[0]})
                $display("FAIL random_b cyc=%0d got %b required %b", i,
                         {b_sync, b_level, b_rise}, {e_sync(1)[0], m_lvl[1][0], e_rise(1)[0]});
            else n_pass++;
`ifdef INPUT_COND_FALL_EDGE_EN
            n_checks++;
            if ({a_fall, b_fall} !== {e_fall(0), e_fall(1)[0]})
                $display("FAIL random_fall cyc=%0d got %b required %b", i,
                         {a_fall, b_fall}, {e_fall(0), e_fall(1)[0]});
            else n_pass++;
`endif
        end
        a_rst_n = 1'b1;
        b_rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_clean_rise();
        test_glitch();
        test_simultaneous();
        test_reset_mid();
        test_fast();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_input_conditioner
`default_nettype wire
